// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 1..DBIT_MAX data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, plus a line-break hold mode.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic                tx_start,
    input  logic [DBIT_MAX-1:0] tx_dataIn,
    input  logic [3:0]          data_bits,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                tx_break,
    output logic                tx,
    output logic                tx_busy,
    output logic                tx_done_tick,
    output logic [2:0]          dbgState
);
    typedef enum logic [2:0] {IDLE, BREAK, START, DATA, PARITY, STOP} stateT;

    localparam int              TW        = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [3:0]      DBITS_MAX = 4'(DBIT_MAX);

    stateT                state;
    logic [TW-1:0]        tickCnt;
    logic [3:0]           bitCnt;
    logic [DBIT_MAX-1:0]  shData;
    logic [3:0]           shBits;
    logic                 shParEn;
    logic                 shParBit;
    logic                 shStop2;
    logic [3:0]           resolvedBits;
    logic                 maskedXor;
    logic                 tickEnd;

    // Out-of-range lengths fall back to the full width; parity only covers sent bits.
    always_comb begin
        resolvedBits = data_bits;
        if (data_bits == 4'd0 || data_bits > DBITS_MAX)
            resolvedBits = DBITS_MAX;
        maskedXor = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++)
            if (4'(i) < resolvedBits)
                maskedXor = maskedXor ^ tx_dataIn[i];
    end

    assign tickEnd  = s_tick && (tickCnt == TICK_LAST);
    assign tx_busy  = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tickCnt      <= '0;
            bitCnt       <= '0;
            shData       <= '0;
            shBits       <= '0;
            shParEn      <= 1'b0;
            shParBit     <= 1'b0;
            shStop2      <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            if (s_tick && state != IDLE && state != BREAK && !tickEnd)
                tickCnt <= tickCnt + 1'b1;
            case (state)
                IDLE: begin
                    // The FIFO still shows the popped word during the done cycle.
                    if (tx_break) begin
                        state <= BREAK;
                        tx    <= 1'b0;
                    end else if (tx_start && !tx_done_tick) begin
                        state    <= START;
                        tx       <= 1'b0;
                        tickCnt  <= '0;
                        bitCnt   <= '0;
                        shData   <= tx_dataIn;
                        shBits   <= resolvedBits;
                        shParEn  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        shParBit <= maskedXor ^ (parity_mode == 2'b10);
                        shStop2  <= stop2;
                    end
                end
                BREAK: begin
                    if (!tx_break) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end
                START: begin
                    if (tickEnd) begin
                        tickCnt <= '0;
                        state   <= DATA;
                        tx      <= shData[0];
                    end
                end
                DATA: begin
                    if (tickEnd) begin
                        tickCnt <= '0;
                        if (bitCnt == shBits - 4'd1) begin
                            bitCnt <= '0;
                            if (shParEn) begin
                                state <= PARITY;
                                tx    <= shParBit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                            shData <= shData >> 1;
                            tx     <= shData[1];
                        end
                    end
                end
                PARITY: begin
                    if (tickEnd) begin
                        tickCnt <= '0;
                        state   <= STOP;
                        tx      <= 1'b1;
                    end
                end
                STOP: begin
                    // bitCnt marks the first stop bit done when two are requested.
                    if (tickEnd) begin
                        tickCnt <= '0;
                        if (shStop2 && bitCnt == 4'd0) begin
                            bitCnt <= 4'd1;
                        end else begin
                            bitCnt       <= '0;
                            state        <= IDLE;
                            tx_done_tick <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter, successor to the fixed-format transmitter. Serialises one frame per accepted word. Frame format is selectable per frame: data length 1..DBIT_MAX, parity none/even/odd, 1 or 2 stop bits. Also supports a line-break mode. Sits between the TX FIFO (tx_start = FIFO not-empty, FIFO pop = tx_done_tick) and the tx pin, timed by the shared baud-rate generator's s_tick.

Parameters:
DBIT_MAX, 8, maximum data bits per frame; width of tx_dataIn.
SB_TICK, 16, s_tick pulses per bit time (oversampling ratio).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
s_tick  input  1  one-clk baud-oversample strobe from the baud generator.
tx_start  input  1  word available (level); sampled only in IDLE.
tx_dataIn  input  DBIT_MAX  word to send, LSB first; bits at or above data_bits are ignored.
data_bits  input  4  data length; legal range 1..DBIT_MAX; 0 or >DBIT_MAX means DBIT_MAX.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx_break  input  1  hold line low while asserted (IDLE only).
tx  output  1  serial line, registered; idle high.
tx_busy  output  1  high whenever state != IDLE (includes BREAK).
tx_done_tick  output  1  one-clk pulse at end of frame; FIFO pop strobe.

Behaviour:
- Reset (synchronous, any state, including mid-frame): next cycle state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, counters=0. An aborted frame produces no done pulse.
- States: IDLE, BREAK, START, DATA, PARITY, STOP.
- IDLE priority: tx_break=1 -> BREAK; else tx_start=1 -> START. On START entry, latch tx_dataIn, the resolved data_bits, parity_mode and stop2 into a shadow register. Config changes mid-frame have no effect.
- tx is registered and reflects the new state from the cycle after the transition. Output per state: START drives 0; DATA drives shadow bit n (n = 0 upward); PARITY drives the parity bit; STOP drives 1.
- Bit timing: a tick counter counts s_tick pulses from 0 to SB_TICK-1. An s_tick in the accept cycle is ignored. A bit ends on the s_tick at count SB_TICK-1; the counter then clears and the state advances.
- Transitions:
  - START -> DATA.
  - DATA -> after bit data_bits-1, go to PARITY if the latched parity_mode is 01 or 10, else to STOP.
  - PARITY -> STOP.
  - STOP lasts SB_TICK ticks (stop2=0) or 2*SB_TICK ticks (stop2=1), then returns to IDLE.
- Parity: even = XOR of the data_bits transmitted bits; odd = its inverse. Ignored upper bits never contribute.
- tx_done_tick is asserted in the same cycle the state returns to IDLE, for exactly one clk.
- Back-to-back frames: the FIFO updates its output the cycle after the pop. IDLE therefore lasts at least 1 clk between frames, and tx stays 1 during it. No word is lost or duplicated while tx_start stays high.
- BREAK: tx=0, tx_busy=1 while tx_break=1. Return to IDLE the cycle after tx_break falls; tx=1 from that point. No done pulse. tx_break asserted mid-frame is ignored until the frame completes.
- s_tick absent: the state machine holds and tx is stable.
- Frame length in ticks = SB_TICK*(1 + data_bits + parity_en + 1 + stop2).

Test Plan:
1. 8N1, tx_dataIn=0x55, s_tick every 4 clk -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 64 clk; single tx_done_tick after 640 clk of frame; tx_busy high throughout.
2. data_bits=7, parity 01 (even), dataIn=0xC1 -> 0,1,0,0,0,0,0,1,P=0,1. Bit 7 is ignored; frame = 10 bit times.
3. data_bits=5, parity 10 (odd), stop2=1, dataIn=0xFF vs 0x1F -> identical waveforms 0,1,1,1,1,1,P=0, then stop high for 32 ticks. Done pulse at 144 ticks.
4. FIFO holding 0x55 then 0x57, tx_start held -> two frames, exactly 2 done pulses, FIFO empty afterwards. Gap between frames: 1-2 clk of tx=1. Second frame carries 0x57.
5. Reset asserted in DATA bit 3 -> next cycle tx=1, tx_busy=0, no done pulse. A subsequent 8N1 frame of 0xA5 is correct.
6. tx_break=1 in IDLE for 100 clk with tx_start=1 -> tx=0 for 100 clk, no frame, no done. Release -> IDLE, then the pending word is sent. Break raised mid-frame -> the frame finishes unaltered first.
